// File: rtl/reg_bank_mp.sv
// Parametrised multi-read-port register bank with half-word write modes, constant read table,
// same-cycle write-to-read forwarding, per-register written flags and a bank-clear sequencer.
module reg_bank_mp #(
  parameter int DW  = 64,
  parameter int AW  = 4,
  parameter int NRD = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              regwen,
  input  logic [DW-1:0]     inA,
  input  logic [AW-1:0]     selwreg,
  input  logic [1:0]        endreg,
  input  logic              clr_start,
  output logic              busy,
  input  logic [NRD*AW-1:0] rdsel,
  input  logic [NRD-1:0]    cnst,
  input  logic [NRD-1:0]    enrreg,
  output logic [NRD*DW-1:0] rdout,
  output logic [NRD-1:0]    rdvld
);
  localparam int HW   = DW / 2;
  localparam int NREG = 1 << AW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic            busy_q;
  logic [NREG-1:0] wflag_q;
  logic [DW-1:0]   bank_q [NREG];

  logic            wr_en;
  logic [DW-1:0]   wr_merged;

  function automatic logic [DW-1:0] merge_write(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] din,
                                                input logic [1:0]    mode);
    logic [DW-1:0] res;
    case (mode)
      2'b00:   res = din;
      2'b01:   res = {din[DW-1:HW], cur[HW-1:0]};
      2'b10:   res = {cur[DW-1:HW], din[HW-1:0]};
      default: res = {din[HW-1:0], din[DW-1:HW]};
    endcase
    return res;
  endfunction

  function automatic logic [HW-1:0] half_const(input logic [1:0] c);
    logic [HW-1:0] res;
    case (c)
      2'b01:   res = HW'(1);
      2'b11:   res = '1;
      default: res = '0;
    endcase
    return res;
  endfunction

  // A half code of 10 is reserved and forces the whole constant to zero.
  function automatic logic [DW-1:0] const_val(input logic [3:0] c);
    logic [DW-1:0] res;
    if (c[1:0] == 2'b10 || c[3:2] == 2'b10) begin
      res = '0;
    end else begin
      res = {half_const(c[3:2]), half_const(c[1:0])};
    end
    return res;
  endfunction

  assign wr_en     = regwen && (state_q == S_IDLE);
  assign wr_merged = merge_write(bank_q[selwreg], inA, endreg);
  assign busy      = busy_q;

  // Storage is intentionally left out of reset; only the clear sequencer zeroes it.
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      bank_q[cnt_q] <= '0;
    end else if (wr_en) begin
      bank_q[selwreg] <= wr_merged;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      wflag_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_en) begin
            wflag_q[selwreg] <= 1'b1;
          end
          if (clr_start) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          wflag_q[cnt_q] <= 1'b0;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == AW'(NREG - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] idx;
    logic [3:0]    code;
    logic [DW-1:0] rd_d;
    logic [DW-1:0] rd_q;
    logic          vld_d;
    logic          vld_q;

    assign idx = rdsel[gi*AW +: AW];

    if (AW >= 4) begin : g_code
      assign code = idx[3:0];
    end else begin : g_code
      assign code = {{(4 - AW){1'b0}}, idx};
    end

    // Forwarding only applies to accepted user writes, never to clear-sequencer writes.
    always_comb begin
      rd_d  = bank_q[idx];
      vld_d = wflag_q[idx];
      if (cnst[gi]) begin
        rd_d  = const_val(code);
        vld_d = 1'b1;
      end else if (wr_en && (selwreg == idx)) begin
        rd_d  = wr_merged;
        vld_d = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_q  <= '0;
        vld_q <= 1'b0;
      end else if (enrreg[gi]) begin
        rd_q  <= rd_d;
        vld_q <= vld_d;
      end
    end

    assign rdout[gi*DW +: DW] = rd_q;
    assign rdvld[gi]          = vld_q;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed plus randomized bench for reg_bank_mp (DW=64, AW=4, NRD=2) against an array-based model.
module tb_reg_bank_mp;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         regwen = 1'b0;
  logic [63:0]  inA = '0;
  logic [3:0]   selwreg = '0;
  logic [1:0]   endreg = '0;
  logic         clr_start = 1'b0;
  logic         busy;
  logic [7:0]   rdsel = '0;
  logic [1:0]   cnst = '0;
  logic [1:0]   enrreg = '0;
  logic [127:0] rdout;
  logic [1:0]   rdvld;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_bank [16];
  bit          m_flag [16];
  bit          m_known[16];
  bit          m_clr;
  int          m_idx;
  logic [63:0] exp_out  [2];
  bit          exp_vld  [2];
  bit          exp_known[2];
  bit          exp_busy;
  logic [63:0] ctab [16];

  reg_bank_mp #(.DW(64), .AW(4), .NRD(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .regwen   (regwen),
    .inA      (inA),
    .selwreg  (selwreg),
    .endreg   (endreg),
    .clr_start(clr_start),
    .busy     (busy),
    .rdsel    (rdsel),
    .cnst     (cnst),
    .enrreg   (enrreg),
    .rdout    (rdout),
    .rdvld    (rdvld)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] half_of(input logic [1:0] c);
    if (c == 2'd1) return 32'd1;
    if (c == 2'd3) return 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  function automatic logic [63:0] const_of(input logic [3:0] c);
    if (c[1:0] == 2'd2 || c[3:2] == 2'd2) return 64'd0;
    return {half_of(c[3:2]), half_of(c[1:0])};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] din,
                                        input logic [1:0] m);
    case (m)
      2'd0:    return din;
      2'd1:    return {din[63:32], cur[31:0]};
      2'd2:    return {cur[63:32], din[31:0]};
      default: return {din[31:0], din[63:32]};
    endcase
  endfunction

  task automatic quiet();
    regwen    = 1'b0;
    clr_start = 1'b0;
    enrreg    = 2'b00;
    cnst      = 2'b00;
  endtask

  task automatic wr(input logic [3:0] r, input logic [63:0] d, input logic [1:0] m);
    regwen  = 1'b1;
    selwreg = r;
    inA     = d;
    endreg  = m;
  endtask

  task automatic set_rd(input int p, input logic [3:0] r, input bit c);
    rdsel[p*4 +: 4] = r;
    cnst[p]         = c;
    enrreg[p]       = 1'b1;
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare.
  task automatic step();
    logic [3:0] idx;
    bit         full;
    for (int p = 0; p < 2; p++) begin
      if (enrreg[p]) begin
        idx = rdsel[p*4 +: 4];
        if (cnst[p]) begin
          exp_out[p]   = const_of(idx);
          exp_vld[p]   = 1'b1;
          exp_known[p] = 1'b1;
        end else if (!m_clr && regwen && selwreg == idx) begin
          exp_out[p]   = merge(m_bank[idx], inA, endreg);
          exp_vld[p]   = 1'b1;
          exp_known[p] = m_known[idx] || endreg == 2'd0 || endreg == 2'd3;
        end else begin
          exp_out[p]   = m_bank[idx];
          exp_vld[p]   = m_flag[idx];
          exp_known[p] = m_known[idx];
        end
      end
    end
    if (m_clr) begin
      m_bank[m_idx]  = 64'd0;
      m_flag[m_idx]  = 1'b0;
      m_known[m_idx] = 1'b1;
      if (m_idx == 15) m_clr = 1'b0;
      m_idx = (m_idx + 1) % 16;
    end else begin
      if (regwen) begin
        full              = (endreg == 2'd0 || endreg == 2'd3);
        m_bank[selwreg]   = merge(m_bank[selwreg], inA, endreg);
        m_known[selwreg]  = m_known[selwreg] || full;
        m_flag[selwreg]   = 1'b1;
      end
      if (clr_start) begin
        m_clr = 1'b1;
        m_idx = 0;
      end
    end
    exp_busy = m_clr;
    @(posedge clock);
    #1;
    chk("busy", 64'(busy), 64'(exp_busy));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rdvld%0d", p), 64'(rdvld[p]), 64'(exp_vld[p]));
      if (exp_known[p]) chk($sformatf("rdout%0d", p), rdout[p*64 +: 64], exp_out[p]);
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      quiet();
      wr(4'(i), {$urandom, $urandom}, 2'd0);
      step();
    end
  endtask

  initial begin
    logic [63:0] v9;
    logic [63:0] v10;
    ctab = '{64'h0, 64'h1, 64'h0, 64'h0000_0000_FFFF_FFFF,
             64'h1_0000_0000, 64'h1_0000_0001, 64'h0, 64'h1_FFFF_FFFF,
             64'h0, 64'h0, 64'h0, 64'h0,
             64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 16; i++) begin
      m_bank[i] = '0; m_flag[i] = 1'b0; m_known[i] = 1'b0;
    end
    m_clr = 1'b0; m_idx = 0; exp_busy = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_out[p] = '0; exp_vld[p] = 1'b0; exp_known[p] = 1'b1;
    end

    // Reset state
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdout0", rdout[63:0], 64'd0);
    chk("rst_rdout1", rdout[127:64], 64'd0);
    chk("rst_rdvld", 64'(rdvld), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Half-word write modes on r3
    quiet(); wr(4'd3, 64'h1111_2222_3333_4444, 2'd0); step();
    quiet(); wr(4'd3, 64'hAAAA_BBBB_CCCC_DDDD, 2'd1); step();
    quiet(); set_rd(0, 4'd3, 1'b0); step();
    chk("r3_mode01", rdout[63:0], 64'hAAAA_BBBB_3333_4444);
    chk("r3_mode01_vld", 64'(rdvld[0]), 64'd1);
    quiet(); wr(4'd3, 64'hAAAA_BBBB_CCCC_DDDD, 2'd3); step();
    quiet(); set_rd(0, 4'd3, 1'b0); step();
    chk("r3_mode11", rdout[63:0], 64'hCCCC_DDDD_AAAA_BBBB);

    // Constant table sweep on both ports
    for (int c = 0; c < 16; c++) begin
      quiet(); set_rd(0, 4'(c), 1'b1); set_rd(1, 4'(c), 1'b1); step();
      chk($sformatf("cnst_p0_%0h", c), rdout[63:0], ctab[c]);
      chk($sformatf("cnst_p1_%0h", c), rdout[127:64], ctab[c]);
    end

    // Forwarding of a low-half write to both ports
    quiet(); wr(4'd5, 64'd0, 2'd0); step();
    quiet(); wr(4'd5, 64'h0123_4567_89AB_CDEF, 2'd2);
    set_rd(0, 4'd5, 1'b0); set_rd(1, 4'd5, 1'b0); step();
    chk("fwd_p0", rdout[63:0], 64'h0000_0000_89AB_CDEF);
    chk("fwd_p1", rdout[127:64], 64'h0000_0000_89AB_CDEF);
    chk("fwd_vld", 64'(rdvld), 64'd3);

    // Written flag on r9, then hold with enrreg=0
    quiet(); set_rd(0, 4'd9, 1'b0); step();
    chk("r9_unwritten_vld", 64'(rdvld[0]), 64'd0);
    v9 = {$urandom, $urandom};
    quiet(); wr(4'd9, v9, 2'd0); step();
    quiet(); set_rd(0, 4'd9, 1'b0); step();
    chk("r9_written_vld", 64'(rdvld[0]), 64'd1);
    chk("r9_value", rdout[63:0], v9);
    quiet(); wr(4'd4, {$urandom, $urandom}, 2'd0); rdsel = 8'h44; cnst = 2'b11; step();
    chk("hold_rdout0", rdout[63:0], v9);

    // Full clear with a dropped mid-clear write
    fill_all();
    quiet(); clr_start = 1'b1; step();
    chk("clr_busy_start", 64'(busy), 64'd1);
    for (int k = 0; k < 16; k++) begin
      quiet();
      if (k == 7) wr(4'd2, 64'hDEAD_BEEF_0BAD_F00D, 2'd0);
      if (k == 3) clr_start = 1'b1;
      set_rd(0, 4'(k), 1'b0);
      step();
      chk("clr_busy", 64'(busy), (k < 15) ? 64'd1 : 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      quiet(); set_rd(0, 4'(2*i), 1'b0); set_rd(1, 4'(2*i+1), 1'b0); step();
      chk("post_clr_p0", rdout[63:0], 64'd0);
      chk("post_clr_p1", rdout[127:64], 64'd0);
      chk("post_clr_vld", 64'(rdvld), 64'd0);
    end

    // Asynchronous reset during clear cycle 5
    fill_all();
    v10 = m_bank[10];
    quiet(); set_rd(0, 4'd10, 1'b0); set_rd(1, 4'd10, 1'b0); step();
    quiet(); clr_start = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      quiet(); step();
    end
    quiet();
    #3;
    reset = 1'b0;
    m_clr = 1'b0; m_idx = 0; exp_busy = 1'b0;
    for (int i = 0; i < 16; i++) m_flag[i] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      exp_out[p] = '0; exp_vld[p] = 1'b0; exp_known[p] = 1'b1;
    end
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rdout0", rdout[63:0], 64'd0);
    chk("arst_rdout1", rdout[127:64], 64'd0);
    chk("arst_rdvld", 64'(rdvld), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    quiet(); set_rd(0, 4'd10, 1'b0); set_rd(1, 4'd2, 1'b0); step();
    chk("r10_retained", rdout[63:0], v10);
    chk("r10_flag", 64'(rdvld[0]), 64'd0);
    chk("r2_cleared", rdout[127:64], 64'd0);
    quiet(); clr_start = 1'b1; step();
    chk("reclr_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 16; k++) begin
      quiet(); step();
    end
    chk("reclr_done", 64'(busy), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      quiet();
      regwen    = 1'($urandom_range(0, 1));
      selwreg   = 4'($urandom_range(0, 15));
      inA       = {$urandom, $urandom};
      endreg    = 2'($urandom_range(0, 3));
      clr_start = ($urandom_range(0, 49) == 0);
      rdsel     = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rdsel[3:0] = selwreg;
      cnst      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) cnst = 2'b00;
      enrreg    = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised successor of the 64-bit/16-entry datapath register bank: configurable data width, register count and number of read ports.
- Keeps the half-word write modes and the constant read table.
- Adds write-to-read forwarding, per-register "written" flags, and a hardware bank-clear sequencer with a busy indication.
- Sits between the load/ALU result bus and the ALU operand registers.

Parameters:
DW, 64, data width in bits; even, >=8; half width HW=DW/2
AW, 4, register index width; NREG=2**AW registers
NRD, 2, number of independent registered read ports (>=1)

Ports:
clock  input  1  master clock, posedge
reset  input  1  asynchronous, active-low master reset
regwen  input  1  write enable for register selwreg
inA  input  DW  write data
selwreg  input  AW  write register index
endreg  input  2  write mode: 00 full, 01 high half, 10 low half, 11 swap halves
clr_start  input  1  start bank-clear sequence (single-cycle pulse, sampled in IDLE only)
busy  output  1  clear sequence in progress, registered
rdsel  input  NRD*AW  per-port read index / constant code; port i uses bits [i*AW +: AW]
cnst  input  NRD  per-port: 1 loads constant, 0 loads bank content
enrreg  input  NRD  per-port load enable of output register
rdout  output  NRD*DW  per-port registered data; port i at [i*DW +: DW]
rdvld  output  NRD  per-port: loaded value came from a written register or a constant

Behaviour:
- Reset (reset=0, asynchronous):
  - rdout=0, rdvld=0, busy=0, FSM=IDLE, clear counter=0, all written flags=0.
  - Bank storage is not reset.
- Write (regwen=1, FSM=IDLE), committed at posedge:
  - 00: bank[selwreg]=inA.
  - 01: high half <= inA[DW-1:HW]; low half kept.
  - 10: low half <= inA[HW-1:0]; high half kept.
  - 11: bank[selwreg]={inA[HW-1:0],inA[DW-1:HW]}.
  - Sets written flag of selwreg.
- Read port i, 1-cycle latency; rdout_i/rdvld_i update only when enrreg[i]=1, otherwise hold:
  - cnst[i]=1: constant from code c=rdsel_i[3:0]; bits above 3 ignored.
    - Low-half code c[1:0]: 00 -> 0, 01 -> 1, 11 -> all-ones.
    - High-half code c[3:2]: same mapping.
    - If either half code is 10, the whole value is 0.
    - rdvld_i=1.
  - cnst[i]=0: rdout_i=bank[rdsel_i], rdvld_i=written flag.
- Forwarding:
  - If regwen=1 in IDLE and selwreg==rdsel_i (cnst[i]=0) in the same cycle, port i loads the post-write merged value (mode applied to the current contents) and rdvld_i=1.
  - All ports may read the same register simultaneously.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start=1; counter=0.
  - In CLEAR, each cycle: bank[counter]=0, flag[counter]=0, counter++.
  - CLEAR -> IDLE after writing index NREG-1; counter wraps to 0.
  - busy=1 exactly NREG cycles, starting the cycle after clr_start is sampled.
- Simultaneous / boundary events:
  - clr_start while busy: ignored.
  - regwen while busy: dropped; no flag set.
  - regwen and clr_start in the same IDLE cycle: the write commits, then clearing starts next cycle and zeroes it.
  - Reads during CLEAR are allowed; no forwarding from clear writes.
  - A read of the register cleared in the same cycle returns its pre-clear value.
  - Reset mid-clear: FSM=IDLE, busy=0 immediately. Partially cleared registers keep their state; all flags are 0.

Test Plan (DW=64, AW=4, NRD=2):
- Reset, write r3=64'h1111_2222_3333_4444 mode 00, then mode 01 with inA=64'hAAAA_BBBB_CCCC_DDDD, read r3 on port0 next cycle -> rdout0=64'hAAAA_BBBB_3333_4444, rdvld0=1; mode 11 with the same inA -> r3=64'hCCCC_DDDD_AAAA_BBBB.
- cnst=1 on both ports, sweep codes 0..F -> 1:0000_0001, 3:0000_0000_FFFF_FFFF, 4:1_0000_0000, 5:1_0000_0001, 7:1_FFFF_FFFF, C:FFFF_FFFF_0000_0000, D:FFFF_FFFF_0000_0001, F:all-ones, others 0; rdvld=1.
- Same cycle: write r5=64'h0123_4567_89AB_CDEF (mode 10, prior r5=0) while both ports read r5 -> both rdout=64'h0000_0000_89AB_CDEF, rdvld=1 next cycle.
- Read never-written r9 after reset -> rdvld=0; write r9, read again -> rdvld=1; enrreg=0 -> outputs hold.
- Fill all 16 registers, pulse clr_start -> busy high 16 cycles; regwen to r2 mid-clear dropped; after busy falls, all reads return 0 with rdvld=0.
- Assert reset low asynchronously (off clock edge) at clear cycle 5 -> busy and rdout go to 0 immediately; r10 retains its pre-clear value; new clr_start after release is accepted.
